// File: rtl/fadd_pipe.sv
// Three-stage pipelined floating-point adder/subtractor with valid/ready flow control.
// Subnormals flush to zero. Rounding is round-to-nearest-even. Flags are {invalid, overflow, inexact}.
module fadd_pipe #(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EW+MW:0]   x1,
  input  logic [EW+MW:0]   x2,
  input  logic             sub,
  input  logic [4:0]       tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EW+MW:0]   y,
  output logic [4:0]       y_tag,
  output logic [2:0]       flags
);
  localparam int AW  = MW + 3;
  localparam int SW  = MW + 5;
  localparam int LZW = $clog2(SW + 1);
  localparam int SHW = $clog2(AW + 1);
  localparam int XW  = EW + 2;
  localparam logic [EW-1:0]  EMAX = {EW{1'b1}};
  localparam logic [EW+MW:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

  // Leading-zero count over the full carry..sticky significand
  function automatic logic [LZW-1:0] lzc_f(input logic [SW-1:0] v);
    logic [LZW-1:0] n;
    n = LZW'(SW);
    for (int i = 0; i < SW; i++) n = v[i] ? LZW'(SW - 1 - i) : n;
    return n;
  endfunction

  logic en_s;
  logic [EW-1:0] ea_s, eb_s, e_big_s, e_sml_s, d_s;
  logic [MW-1:0] ma_s, mb_s, m_big_s, m_sml_s;
  logic sa_s, sb_s, sign_big_s, a_big_s;
  logic a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
  logic [EW+MW-1:0] mag_a_s, mag_b_s;
  logic [SHW-1:0] dsat_s;
  logic [2*AW-1:0] ext_s;
  logic spec_s;
  logic [EW+MW:0] spec_y_s;
  logic [2:0] spec_fl_s;

  logic s1_valid_r, s1_spec_r, s1_sign_r, s1_sticky_r, s1_sub_r;
  logic [4:0] s1_tag_r;
  logic [EW+MW:0] s1_spec_y_r;
  logic [2:0] s1_spec_fl_r;
  logic [EW-1:0] s1_exp_r;
  logic [AW-1:0] s1_a_r, s1_b_r;

  logic [SW-1:0] sum_s;
  logic s2_valid_r, s2_spec_r, s2_sign_r;
  logic [4:0] s2_tag_r;
  logic [EW+MW:0] s2_spec_y_r;
  logic [2:0] s2_spec_fl_r;
  logic [EW-1:0] s2_exp_r;
  logic [SW-1:0] s2_sum_r;
  logic [LZW-1:0] s2_lz_r;

  logic [SW-2:0] norm_s;
  logic [XW-1:0] exp_n_s, exp_r_s;
  logic [MW+1:0] rnd_s;
  logic [MW-1:0] mant_out_s;
  logic g_s, r_s, st_s, up_s;
  logic [EW+MW:0] res_y_s;
  logic [2:0] res_fl_s;

  assign en_s     = !out_valid | out_ready;
  assign in_ready = en_s;

  // Stage 1 combinational: unpack, classify, order by magnitude, align the smaller operand
  always_comb begin
    ea_s = x1[EW+MW-1:MW];
    eb_s = x2[EW+MW-1:MW];
    ma_s = x1[MW-1:0];
    mb_s = x2[MW-1:0];
    sa_s = x1[EW+MW];
    sb_s = x2[EW+MW] ^ sub;
    a_zero_s = (ea_s == {EW{1'b0}});
    b_zero_s = (eb_s == {EW{1'b0}});
    a_inf_s  = (ea_s == EMAX) && (ma_s == {MW{1'b0}});
    b_inf_s  = (eb_s == EMAX) && (mb_s == {MW{1'b0}});
    a_nan_s  = (ea_s == EMAX) && (ma_s != {MW{1'b0}});
    b_nan_s  = (eb_s == EMAX) && (mb_s != {MW{1'b0}});
    mag_a_s  = a_zero_s ? {(EW+MW){1'b0}} : x1[EW+MW-1:0];
    mag_b_s  = b_zero_s ? {(EW+MW){1'b0}} : x2[EW+MW-1:0];
    a_big_s  = (mag_a_s >= mag_b_s);
    if (a_big_s) begin
      sign_big_s = sa_s; e_big_s = ea_s; m_big_s = ma_s; e_sml_s = eb_s; m_sml_s = mb_s;
    end else begin
      sign_big_s = sb_s; e_big_s = eb_s; m_big_s = mb_s; e_sml_s = ea_s; m_sml_s = ma_s;
    end
    d_s    = e_big_s - e_sml_s;
    dsat_s = (32'(d_s) >= 32'(AW)) ? SHW'(AW) : SHW'(d_s);
    // Bits shifted past the round position land in the low half and collapse to sticky
    ext_s  = {1'b1, m_sml_s, 2'b00, {AW{1'b0}}} >> dsat_s;
    spec_s = a_nan_s | b_nan_s | a_inf_s | b_inf_s | a_zero_s | b_zero_s;
    spec_fl_s = 3'b000;
    if (a_nan_s || b_nan_s || (a_inf_s && b_inf_s && (sa_s != sb_s))) begin
      spec_y_s  = QNAN;
      spec_fl_s = 3'b100;
    end else if (a_inf_s) begin
      spec_y_s = {sa_s, EMAX, {MW{1'b0}}};
    end else if (b_inf_s) begin
      spec_y_s = {sb_s, EMAX, {MW{1'b0}}};
    end else if (a_zero_s && b_zero_s) begin
      spec_y_s = {sa_s & sb_s, {(EW+MW){1'b0}}};
    end else if (b_zero_s) begin
      spec_y_s = x1;
    end else if (a_zero_s) begin
      spec_y_s = {sb_s, x2[EW+MW-1:0]};
    end else begin
      spec_y_s = {(EW+MW+1){1'b0}};
    end
  end

  // Stage 2 combinational: significand add/subtract with sticky as the lowest bit
  always_comb begin
    if (s1_sub_r) begin
      sum_s = {1'b0, s1_a_r, 1'b0} - {1'b0, s1_b_r, s1_sticky_r};
    end else begin
      sum_s = {1'b0, s1_a_r, 1'b0} + {1'b0, s1_b_r, s1_sticky_r};
    end
  end

  // Stage 3 combinational: normalise, round to nearest even, pack and raise flags
  always_comb begin
    if (s2_lz_r == {LZW{1'b0}}) begin
      norm_s = {s2_sum_r[SW-1:2], |s2_sum_r[1:0]};
    end else begin
      norm_s = s2_sum_r[SW-2:0] << (s2_lz_r - LZW'(1));
    end
    exp_n_s = {2'b00, s2_exp_r} + XW'(1) - XW'(s2_lz_r);
    g_s  = norm_s[2];
    r_s  = norm_s[1];
    st_s = norm_s[0];
    up_s = g_s & (r_s | st_s | norm_s[3]);
    rnd_s   = {1'b0, norm_s[MW+3:3]} + (MW+2)'(up_s);
    exp_r_s = exp_n_s + XW'(rnd_s[MW+1]);
    mant_out_s = rnd_s[MW+1] ? rnd_s[MW:1] : rnd_s[MW-1:0];
    if (s2_spec_r) begin
      res_y_s  = s2_spec_y_r;
      res_fl_s = s2_spec_fl_r;
    end else if (s2_sum_r == {SW{1'b0}}) begin
      res_y_s  = {(EW+MW+1){1'b0}};
      res_fl_s = 3'b000;
    end else if (exp_n_s[XW-1] || (exp_n_s == {XW{1'b0}})) begin
      res_y_s  = {s2_sign_r, {(EW+MW){1'b0}}};
      res_fl_s = 3'b001;
    end else if (exp_r_s >= {2'b00, EMAX}) begin
      res_y_s  = {s2_sign_r, EMAX, {MW{1'b0}}};
      res_fl_s = 3'b011;
    end else begin
      res_y_s  = {s2_sign_r, exp_r_s[EW-1:0], mant_out_s};
      res_fl_s = {2'b00, g_s | r_s | st_s};
    end
  end

  // Valid bits and output register; results are only loaded when a real result arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
      out_valid  <= 1'b0;
      y          <= {(EW+MW+1){1'b0}};
      y_tag      <= 5'd0;
      flags      <= 3'b000;
    end else if (en_s) begin
      s1_valid_r <= in_valid;
      s2_valid_r <= s1_valid_r;
      out_valid  <= s2_valid_r;
      if (s2_valid_r) begin
        y     <= res_y_s;
        y_tag <= s2_tag_r;
        flags <= res_fl_s;
      end
    end
  end

  // Stage data registers, advanced only with the pipeline and only for valid entries
  always_ff @(posedge clk) begin
    if (en_s && in_valid) begin
      s1_tag_r     <= tag;
      s1_spec_r    <= spec_s;
      s1_spec_y_r  <= spec_y_s;
      s1_spec_fl_r <= spec_fl_s;
      s1_sign_r    <= sign_big_s;
      s1_exp_r     <= e_big_s;
      s1_a_r       <= {1'b1, m_big_s, 2'b00};
      s1_b_r       <= ext_s[2*AW-1:AW];
      s1_sticky_r  <= |ext_s[AW-1:0];
      s1_sub_r     <= sa_s ^ sb_s;
    end
    if (en_s && s1_valid_r) begin
      s2_tag_r     <= s1_tag_r;
      s2_spec_r    <= s1_spec_r;
      s2_spec_y_r  <= s1_spec_y_r;
      s2_spec_fl_r <= s1_spec_fl_r;
      s2_sign_r    <= s1_sign_r;
      s2_exp_r     <= s1_exp_r;
      s2_sum_r     <= sum_s;
      s2_lz_r      <= lzc_f(sum_s);
    end
  end
endmodule

// File: tb/tb_fadd_pipe.sv
// Directed self-checking bench for fadd_pipe at single precision (EW=8, MW=23).
module tb_fadd_pipe;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, sub, out_valid, out_ready;
  logic [31:0] x1, x2, y;
  logic [4:0]  tag, y_tag;
  logic [2:0]  flags;
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fadd_pipe #(.EW(8), .MW(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .x2(x2), .sub(sub), .tag(tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .y_tag(y_tag), .flags(flags)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // One isolated operation: exact 3-cycle latency, then result, tag and flags
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [4:0] t,
                        input logic [31:0] ey, input logic [2:0] ef);
    @(negedge clk);
    x1 = a; x2 = b; sub = s; tag = t; in_valid = 1'b1;
    #1 check({name, "/in_ready"}, 64'(in_ready), 64'(1));
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check({name, "/early"}, 64'(out_valid), 64'(0));
    @(negedge clk);
    check({name, "/valid"}, 64'(out_valid), 64'(1));
    check({name, "/y"}, 64'(y), 64'(ey));
    check({name, "/tag"}, 64'(y_tag), 64'(t));
    check({name, "/flags"}, 64'(flags), 64'(ef));
  endtask

  logic [31:0] st_a [5] = '{32'h3F800000, 32'h40000000, 32'h3F800001, 32'h3F800000, 32'h7F7FFFFF};
  logic [31:0] st_b [5] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40000000, 32'h7F7FFFFF};
  logic        st_s [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [31:0] st_y [5] = '{32'h40000000, 32'h40400000, 32'h34000000, 32'hBF800000, 32'h7F800000};
  logic [2:0]  st_f [5] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b011};
  logic [31:0] q_y [$];
  logic [4:0]  q_t [$];
  logic [2:0]  q_f [$];

  initial begin
    int idx, got;
    logic [31:0] hy;
    logic [4:0]  ht;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sub = 1'b0;
    x1 = 32'd0; x2 = 32'd0; tag = 5'd0;
    repeat (2) @(negedge clk);
    check("rst/out_valid", 64'(out_valid), 64'(0));
    check("rst/y", 64'(y), 64'(0));
    check("rst/tag", 64'(y_tag), 64'(0));
    check("rst/flags", 64'(flags), 64'(0));
    rst = 1'b0;
    #1 check("rst/in_ready", 64'(in_ready), 64'(1));

    run_op("add_1_1",     32'h3F800000, 32'h3F800000, 1'b0, 5'd3,  32'h40000000, 3'b000);
    run_op("cancel",      32'h40400000, 32'h40400000, 1'b1, 5'd4,  32'h00000000, 3'b000);
    run_op("sub_ulp",     32'h3F800001, 32'h3F800000, 1'b1, 5'd5,  32'h34000000, 3'b000);
    run_op("tie_even",    32'h3F800000, 32'h33800000, 1'b0, 5'd6,  32'h3F800000, 3'b001);
    run_op("tie_odd",     32'h3F800001, 32'h33800000, 1'b0, 5'd7,  32'h3F800002, 3'b001);
    run_op("ovf",         32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 5'd8,  32'h7F800000, 3'b011);
    run_op("inf_m_inf",   32'h7F800000, 32'h7F800000, 1'b1, 5'd9,  32'h7FC00000, 3'b100);
    run_op("nan_in",      32'h7FC00001, 32'h3F800000, 1'b0, 5'd10, 32'h7FC00000, 3'b100);
    run_op("ninf_p_fin",  32'hFF800000, 32'h3F800000, 1'b0, 5'd11, 32'hFF800000, 3'b000);
    run_op("inf_p_inf",   32'h7F800000, 32'h7F800000, 1'b0, 5'd12, 32'h7F800000, 3'b000);
    run_op("a_p_nzero",   32'h3FC00000, 32'h80000000, 1'b0, 5'd13, 32'h3FC00000, 3'b000);
    run_op("nz_m_pz",     32'h80000000, 32'h00000000, 1'b1, 5'd14, 32'h80000000, 3'b000);
    run_op("pz_p_nz",     32'h00000000, 32'h80000000, 1'b0, 5'd15, 32'h00000000, 3'b000);
    run_op("zero_m_b",    32'h00000000, 32'h3F800000, 1'b1, 5'd16, 32'hBF800000, 3'b000);
    run_op("subnorm_a",   32'h00000001, 32'h3F800000, 1'b0, 5'd17, 32'h3F800000, 3'b000);
    run_op("borrow_exact",32'h3F800000, 32'h33800000, 1'b1, 5'd18, 32'h3F7FFFFF, 3'b000);
    run_op("sticky_sub",  32'h3F800000, 32'h32800000, 1'b1, 5'd19, 32'h3F800000, 3'b001);
    run_op("align_add",   32'h40000000, 32'h3F800000, 1'b0, 5'd20, 32'h40400000, 3'b000);
    run_op("swap_sub",    32'h3F800000, 32'h40000000, 1'b1, 5'd21, 32'hBF800000, 3'b000);
    run_op("carry_tie",   32'h3F800001, 32'h3F800000, 1'b0, 5'd22, 32'h40000000, 3'b001);
    run_op("underflow",   32'h80C00000, 32'h00800000, 1'b0, 5'd23, 32'h80000000, 3'b001);
    run_op("round_ovf",   32'h7F7FFFFF, 32'h73000000, 1'b0, 5'd24, 32'h7F800000, 3'b011);

    // Back-to-back stream with the consumer stalled for loop cycles 4..7
    idx = 0; got = 0; hy = 32'd0; ht = 5'd0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      @(negedge clk);
      out_ready = !(c >= 4 && c <= 7);
      in_valid = (idx < 5);
      if (idx < 5) begin
        x1 = st_a[idx]; x2 = st_b[idx]; sub = st_s[idx]; tag = 5'(idx + 25);
      end
      #1;
      if (out_valid && !out_ready) begin
        check("bp/in_ready", 64'(in_ready), 64'(0));
        if (c == 4) begin
          hy = y; ht = y_tag;
        end else begin
          check("bp/hold_y", 64'(y), 64'(hy));
          check("bp/hold_tag", 64'(y_tag), 64'(ht));
        end
      end
      if (out_valid && out_ready) begin
        if (q_y.size() == 0) begin
          check("bp/unexpected", 64'(q_y.size()), 64'(1));
        end else begin
          check("bp/y", 64'(y), 64'(q_y.pop_front()));
          check("bp/tag", 64'(y_tag), 64'(q_t.pop_front()));
          check("bp/flags", 64'(flags), 64'(q_f.pop_front()));
          got++;
        end
      end
      if (in_valid && in_ready) begin
        q_y.push_back(st_y[idx]); q_t.push_back(5'(idx + 25)); q_f.push_back(st_f[idx]);
        idx++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp/accepted", 64'(idx), 64'(5));
    check("bp/delivered", 64'(got), 64'(5));
    repeat (3) begin
      @(negedge clk);
      check("bp/no_dup", 64'(out_valid), 64'(0));
    end

    // Reset with two operations in flight
    @(negedge clk);
    x1 = 32'h3F800000; x2 = 32'h3F800000; sub = 1'b0; tag = 5'd30; in_valid = 1'b1;
    @(negedge clk);
    x1 = 32'h40000000; x2 = 32'h3F800000; tag = 5'd31;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst/out_valid", 64'(out_valid), 64'(0));
    check("mid_rst/y", 64'(y), 64'(0));
    check("mid_rst/tag", 64'(y_tag), 64'(0));
    check("mid_rst/flags", 64'(flags), 64'(0));
    repeat (5) begin
      @(negedge clk);
      check("mid_rst/no_result", 64'(out_valid), 64'(0));
    end
    run_op("after_rst",   32'h40000000, 32'h3F800000, 1'b0, 5'd2,  32'h40400000, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
